// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer arbiter; display reads > cell read-modify-write > clear.
// Optional background clear engine is built only when FB_CLEAR_EN is defined.
module fb_arbiter #(
  parameter int WORDS_PER_LINE = 80,
  parameter int LINES          = 480,
  parameter int ADDR_W         = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [15:0]       disp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [8:0]        wr_y,
  input  logic [1:0]        wr_t,
  output logic              wr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = WORDS_PER_LINE * LINES;

  typedef enum logic [1:0] {IDLE, W_READ, W_CAPTURE, W_WRITE} state_t;

  // Handshake: a write request transfers in any cycle where wr_valid and wr_ready
  // are both high; exactly one wr_done pulse follows each transferred request.
  state_t            state;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_sel;
  logic [1:0]        wr_type;
  logic [15:0]       hold;
  logic [15:0]       merged;
  logic              accept;
  logic              in_range;
  logic              clr_go;
  logic [ADDR_W-1:0] clr_addr;

  assign dbg_state = state;
  assign disp_data = mem_rdata;
  assign wr_ready  = !reset && (state == IDLE) && !clear_busy;
  assign accept    = wr_valid && wr_ready;
  assign in_range  = (32'(wr_x) < 32'(WORDS_PER_LINE * 8)) && (32'(wr_y) < 32'(LINES));

  always_comb begin
    merged = mem_rdata;
    merged[{wr_sel, 1'b0} +: 2] = wr_type;
  end

  // Port mux: display always wins; the writer and clear engine only use idle cycles.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (!reset) begin
      if (disp_req) begin
        mem_addr = disp_addr;
      end else if (state == W_READ) begin
        mem_addr = wr_addr;
      end else if (state == W_WRITE) begin
        mem_addr  = wr_addr;
        mem_we    = 1'b1;
        mem_wdata = hold;
      end else if (clr_go) begin
        mem_addr = clr_addr;
        mem_we   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wr_addr    <= '0;
      wr_sel     <= '0;
      wr_type    <= '0;
      hold       <= '0;
      wr_done    <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= disp_req;
      wr_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            wr_addr <= ADDR_W'(wr_y) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(wr_x[9:3]);
            wr_sel  <= wr_x[2:0];
            wr_type <= wr_t;
            // Off-screen cells are acknowledged without touching memory.
            if (in_range) state <= W_READ;
            else          wr_done <= 1'b1;
          end
        end
        W_READ: begin
          if (!disp_req) state <= W_CAPTURE;
        end
        W_CAPTURE: begin
          hold  <= merged;
          state <= W_WRITE;
        end
        W_WRITE: begin
          if (!disp_req) begin
            wr_done <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FB_CLEAR_EN
  logic clear_pend;

  assign clr_go = clear_busy && (state == IDLE) && !disp_req;

  // A clear requested while a write is in flight waits until the writer is idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      clear_busy <= 1'b0;
      clear_pend <= 1'b0;
      clr_addr   <= '0;
    end else if (clear_busy) begin
      if (clr_go) begin
        clr_addr <= clr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (clr_addr == ADDR_W'(DEPTH - 1)) clear_busy <= 1'b0;
      end
    end else if ((clear_start || clear_pend) && (state == IDLE) && !accept) begin
      clear_busy <= 1'b1;
      clear_pend <= 1'b0;
      clr_addr   <= '0;
    end else if (clear_start) begin
      clear_pend <= 1'b1;
    end
  end
`else
  logic clear_start_unused;

  assign clear_start_unused = clear_start;
  assign clear_busy         = 1'b0;
  assign clr_go             = 1'b0;
  assign clr_addr           = '0;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed and randomized checks of fb_arbiter against a word-array model
// of the framebuffer; clear scenarios run when FB_CLEAR_EN is defined.
module tb_fb_arbiter;

  localparam int WPL   = 80;
  localparam int LINES = 480;
  localparam int DEPTH = WPL * LINES;
  localparam int AW    = 16;

  // clock/reset
  logic clock = 1'b0;
  always #10 clock = ~clock;

  logic          reset;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [15:0]   disp_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [9:0]    wr_x;
  logic [8:0]    wr_y;
  logic [1:0]    wr_t;
  logic          wr_done;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;
  logic          clear_start;
  logic          clear_busy;
  logic [1:0]    dbg_state;

  fb_arbiter #(.WORDS_PER_LINE(WPL), .LINES(LINES), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_t(wr_t),
    .wr_done(wr_done), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .clear_start(clear_start), .clear_busy(clear_busy),
    .dbg_state(dbg_state)
  );

  // RAM with 1-cycle read latency, plus bench-side fill/load ports
  logic [15:0]   ram [0:DEPTH-1];
  logic          fill_en;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_data;

  function automatic logic [15:0] pat(int i);
    return 16'(i * 40503) ^ 16'hA5C3;
  endfunction

  always @(posedge clock) begin
    if (fill_en) for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
    else if (load_en) ram[load_addr] <= load_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // reference model and scoreboard state
  logic [15:0]   ref_mem [0:DEPTH-1];
  int            total = 0;
  int            bad = 0;
  int            we_cnt = 0;
  int            dv_cnt = 0;
  int            done_cnt = 0;
  logic          prev_req = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic          rand_disp = 1'b0;
  logic          done_seen, rdy_seen, busy_seen, obs_we;
  logic [AW-1:0] obs_addr;
  logic [15:0]   obs_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input int x, input int y, input int t);
    int a, sh;
    logic [15:0] m;
    if (x < WPL * 8 && y < LINES) begin
      a  = y * WPL + x / 8;
      sh = 2 * (x % 8);
      m  = 16'(3 << sh);
      ref_mem[a] = (ref_mem[a] & ~m) | 16'(t << sh);
    end
  endtask

  // one clock: sample and check at negedge, then drive after the next posedge
  task automatic tick();
    @(negedge clock);
    if (!reset) begin
      chk("disp_valid", disp_valid, prev_req);
      if (prev_req) chk("disp_data", disp_data, ref_mem[prev_addr]);
      if (disp_req) begin
        chk("disp_addr_pass", mem_addr, disp_addr);
        chk("disp_no_we", mem_we, 1'b0);
      end
    end
    if (mem_we) we_cnt++;
    if (disp_valid) dv_cnt++;
    if (wr_done) done_cnt++;
    done_seen = wr_done;
    rdy_seen  = wr_ready;
    busy_seen = clear_busy;
    obs_we    = mem_we;
    obs_addr  = mem_addr;
    obs_wdata = mem_wdata;
    prev_req  = disp_req && !reset;
    prev_addr = disp_addr;
    @(posedge clock);
    #1;
    if (rand_disp) begin
      disp_req  = ($urandom_range(0, 3) == 0);
      disp_addr = AW'($urandom_range(0, DEPTH - 1));
    end
  endtask

  // driver: issue one cell write, wait for wr_done, update the model
  task automatic do_write(input int x, input int y, input int t, input logic with_clear,
                          output int lat);
    int we0, waits;
    logic acc, done;
    wr_x = 10'(x); wr_y = 9'(y); wr_t = 2'(t);
    wr_valid = 1'b1; clear_start = with_clear;
    acc = 1'b0; waits = 0;
    while (!acc && waits < 50) begin
      tick();
      acc = rdy_seen;
      waits++;
    end
    wr_valid = 1'b0; clear_start = 1'b0;
    chk("wr_accept", acc, 1'b1);
    we0 = we_cnt; lat = 0; done = 1'b0;
    while (!done && lat < 60) begin
      tick();
      lat++;
      done = done_seen;
    end
    chk("wr_done_seen", done, 1'b1);
    chk("wr_we_count", we_cnt - we0, (x < WPL * 8 && y < LINES) ? 1 : 0);
    model_write(x, y, t);
  endtask

  task automatic scan(input string tag);
    int nbad;
    nbad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) nbad++;
    chk(tag, nbad, 0);
  endtask

  initial begin
    int lat, dv0, we0, d0, nbusy, err, ea, k, x, y;
    reset = 1'b1; disp_req = 1'b0; disp_addr = '0; wr_valid = 1'b0;
    wr_x = '0; wr_y = '0; wr_t = '0; clear_start = 1'b0;
    fill_en = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
    tick();
    fill_en = 1'b0;
    tick();
    tick();
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_disp_valid", disp_valid, 1'b0);
    chk("rst_wr_done", wr_done, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_clear_busy", clear_busy, 1'b0);
    reset = 1'b0;
    load_en = 1'b1; load_addr = 16'd161; load_data = 16'hFFFF;
    ref_mem[161] = 16'hFFFF;
    tick();
    load_en = 1'b0;

    // directed: x=9 y=2 t=1 over 0xFFFF, cycle by cycle
    wr_x = 10'd9; wr_y = 9'd2; wr_t = 2'd1; wr_valid = 1'b1;
    tick();
    chk("t0_ready", rdy_seen, 1'b1);
    wr_valid = 1'b0;
    tick();
    chk("t1_read_addr", obs_addr, 161);
    chk("t1_read_we", obs_we, 1'b0);
    tick();
    chk("t2_capture_we", obs_we, 1'b0);
    tick();
    chk("t3_write_we", obs_we, 1'b1);
    chk("t3_write_addr", obs_addr, 161);
    chk("t3_write_data", obs_wdata, 16'hFFF7);
    tick();
    chk("t4_done", done_seen, 1'b1);
    chk("t4_ready", rdy_seen, 1'b1);
    model_write(9, 2, 1);

    // directed: four display reads of addr 5 stall the writer by four cycles
    wr_x = 10'd17; wr_y = 9'd3; wr_t = 2'd3; wr_valid = 1'b1;
    tick();
    chk("d_ready", rdy_seen, 1'b1);
    wr_valid = 1'b0; disp_req = 1'b1; disp_addr = 16'd5;
    dv0 = dv_cnt; lat = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      lat++;
    end
    disp_req = 1'b0;
    while (!done_seen && lat < 40) begin
      tick();
      lat++;
    end
    chk("d_write_latency", lat, 8);
    chk("d_disp_pulses", dv_cnt - dv0, 4);
    model_write(17, 3, 3);

    // boundaries: off-screen column/row and the last on-screen cell
    do_write(640, 0, 2, 1'b0, lat);
    chk("oor_x_latency", lat, 1);
    do_write(5, 480, 1, 1'b0, lat);
    chk("oor_y_latency", lat, 1);
    do_write(639, 479, 2, 1'b0, lat);
    chk("last_cell_latency", lat, 4);

    // reset during W_CAPTURE drops the write
    wr_x = 10'd100; wr_y = 9'd100; wr_t = 2'd3; wr_valid = 1'b1;
    we0 = we_cnt; d0 = done_cnt;
    tick();
    wr_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rstcap_we", obs_we, 1'b0);
    reset = 1'b0;
    tick();
    chk("rstcap_ready", rdy_seen, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("rstcap_no_we", we_cnt - we0, 0);
    chk("rstcap_no_done", done_cnt - d0, 0);

    // randomized writes under random display traffic
    rand_disp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (n % 3 == 0) begin
        x = $urandom_range(0, 15); y = 7;
      end else begin
        x = $urandom_range(0, 679); y = $urandom_range(0, 499);
      end
      do_write(x, y, $urandom_range(0, 3), 1'b0, lat);
      if (x >= WPL * 8 || y >= LINES) chk("rand_oor_latency", lat, 1);
      else chk("rand_min_latency", lat >= 4, 1'b1);
      k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++) tick();
    end
    rand_disp = 1'b0; disp_req = 1'b0;
    tick();
    tick();
    scan("scan_after_writes");

`ifdef FB_CLEAR_EN
    // clear with no display traffic
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    nbusy = 0; err = 0; ea = 0; k = 0;
    while (k < 40000) begin
      tick();
      k++;
      if (busy_seen) begin
        nbusy++;
        if (rdy_seen) err++;
        if (!(obs_we && obs_addr == AW'(ea) && obs_wdata == 16'h0)) err++;
        ea++;
      end else if (nbusy > 0) begin
        break;
      end
    end
    chk("clear_busy_cycles", nbusy, DEPTH);
    chk("clear_sequence_errs", err, 0);
    chk("clear_end_we", obs_we, 1'b0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0;
    scan("scan_after_clear");

    // clear requested together with an accepted write to word 0
    fill_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
    tick();
    fill_en = 1'b0;
    do_write(3, 0, 2, 1'b1, lat);
    chk("clr_rmw_latency", lat, 4);
    chk("clr_rmw_word0", ram[0], ref_mem[0]);
    nbusy = 0; k = 0;
    while (k < 40000) begin
      tick();
      k++;
      if (busy_seen) nbusy++;
      else if (nbusy > 0) break;
    end
    chk("clr2_busy_cycles", nbusy, DEPTH);
    chk("clr2_word0_zero", ram[0], 16'h0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0;
    scan("scan_after_clear2");
`else
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    tick();
    chk("noclr_busy", busy_seen, 1'b0);
    chk("noclr_ready", rdy_seen, 1'b1);
    chk("noclr_no_we", obs_we, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
